// File: rtl/lpif_pkg.sv
// Shared LPIF definitions: packet-path state encoding, default beat width and
// the end-of-packet byte marker helper used by both the TX and RX framing paths.
package lpif_pkg;

  localparam int LPIF_DATA_BYTES = 8;
  localparam int LPIF_MAX_BYTES  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_DLLP = 2'd2
  } lpif_state_e;

  // One-hot at the highest set bit; callers zero-extend their mask to the max width.
  function automatic logic [LPIF_MAX_BYTES-1:0] last_byte_onehot(
    input logic [LPIF_MAX_BYTES-1:0] bytevalid
  );
    logic [LPIF_MAX_BYTES-1:0] oh;
    oh = '0;
    for (int i = 0; i < LPIF_MAX_BYTES; i++) begin
      if (bytevalid[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/lpif_tx_grant.sv
// Packet grant decision for the LPIF TX arbiter: DLLP priority, with a
// run counter that hands the path to a waiting TLP after MAX_DLLP_RUN DLLPs.
module lpif_tx_grant #(
  parameter int MAX_DLLP_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_idle,
  input  logic tx_enable,
  input  logic tlp_req,
  input  logic dllp_req,
  input  logic tlp_valid,
  input  logic accept,
  output logic gnt_tlp,
  output logic gnt_dllp
);

  logic [3:0] dllp_run_q, dllp_run_d;
  logic       tlp_starved;

  always_comb begin
    tlp_starved = (dllp_run_q >= 4'(MAX_DLLP_RUN));
    gnt_tlp     = 1'b0;
    gnt_dllp    = 1'b0;
    if (in_idle && tx_enable) begin
      if (tlp_req && dllp_req) begin
        gnt_tlp  = tlp_starved;
        gnt_dllp = !tlp_starved;
      end else begin
        gnt_tlp  = tlp_req;
        gnt_dllp = dllp_req;
      end
    end

    // Only grants whose first beat is actually taken move the counter.
    dllp_run_d = dllp_run_q;
    if (gnt_tlp && accept) begin
      dllp_run_d = 4'd0;
    end else if (gnt_dllp && accept && tlp_valid) begin
      if (dllp_run_q != 4'hF) dllp_run_d = dllp_run_q + 4'd1;
    end else if (in_idle && !tlp_valid) begin
      dllp_run_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dllp_run_q <= 4'd0;
    else        dllp_run_q <= dllp_run_d;
  end

endmodule

// File: rtl/lpif_tx_packet_arbiter.sv
// Packet-atomic arbiter sharing the LPIF TX byte path between TLP and DLLP sources.
// Optional LPIF_TX_EDB_EN adds tlp_abort / out_tlpedb for nullified TLP endings.
module lpif_tx_packet_arbiter
  import lpif_pkg::*;
#(
  parameter int DATA_BYTES   = LPIF_DATA_BYTES,
  parameter int MAX_DLLP_RUN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_enable,
  input  logic                    tlp_valid,
  input  logic                    tlp_sop,
  input  logic                    tlp_eop,
  input  logic [8*DATA_BYTES-1:0] tlp_data,
  input  logic [DATA_BYTES-1:0]   tlp_bytevalid,
  output logic                    tlp_ready,
  input  logic                    dllp_valid,
  input  logic                    dllp_sop,
  input  logic                    dllp_eop,
  input  logic [8*DATA_BYTES-1:0] dllp_data,
  input  logic [DATA_BYTES-1:0]   dllp_bytevalid,
  output logic                    dllp_ready,
`ifdef LPIF_TX_EDB_EN
  input  logic                    tlp_abort,
  output logic [DATA_BYTES-1:0]   out_tlpedb,
`endif
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_bytevalid,
  output logic [DATA_BYTES-1:0]   out_tlpstart,
  output logic [DATA_BYTES-1:0]   out_tlpend,
  output logic [DATA_BYTES-1:0]   out_dllpstart,
  output logic [DATA_BYTES-1:0]   out_dllpend,
  output logic                    busy
);

  localparam logic [DATA_BYTES-1:0] FIRST_OH = DATA_BYTES'(1);

  lpif_state_e state_q, state_d;

  logic                    load;
  logic                    gnt_tlp, gnt_dllp;
  logic                    sel_tlp, sel_dllp;
  logic [DATA_BYTES-1:0]   tlp_last, dllp_last;

  logic                    out_valid_q, out_valid_d;
  logic [8*DATA_BYTES-1:0] out_data_q, out_data_d;
  logic [DATA_BYTES-1:0]   out_bytevalid_q, out_bytevalid_d;
  logic [DATA_BYTES-1:0]   out_tlpstart_q, out_tlpstart_d;
  logic [DATA_BYTES-1:0]   out_tlpend_q, out_tlpend_d;
  logic [DATA_BYTES-1:0]   out_dllpstart_q, out_dllpstart_d;
  logic [DATA_BYTES-1:0]   out_dllpend_q, out_dllpend_d;
`ifdef LPIF_TX_EDB_EN
  logic [DATA_BYTES-1:0]   out_tlpedb_q, out_tlpedb_d;
`endif

  assign load = !out_valid_q || out_ready;

  lpif_tx_grant #(.MAX_DLLP_RUN(MAX_DLLP_RUN)) u_grant (
    .clk       (clk),
    .reset     (reset),
    .in_idle   (state_q == ST_IDLE),
    .tx_enable (tx_enable),
    .tlp_req   (tlp_valid && tlp_sop),
    .dllp_req  (dllp_valid && dllp_sop),
    .tlp_valid (tlp_valid),
    .accept    (load),
    .gnt_tlp   (gnt_tlp),
    .gnt_dllp  (gnt_dllp)
  );

  always_comb begin
    state_d    = state_q;
    tlp_ready  = 1'b0;
    dllp_ready = 1'b0;
    sel_tlp    = 1'b0;
    sel_dllp   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_tlp) begin
          tlp_ready = load;
          sel_tlp   = load;
          if (load && !tlp_eop) state_d = ST_TLP;
        end else if (gnt_dllp) begin
          dllp_ready = load;
          sel_dllp   = load;
          if (load && !dllp_eop) state_d = ST_DLLP;
        end
      end
      ST_TLP: begin
        tlp_ready = load;
        sel_tlp   = load && tlp_valid;
        if (sel_tlp && tlp_eop) state_d = ST_IDLE;
      end
      ST_DLLP: begin
        dllp_ready = load;
        sel_dllp   = load && dllp_valid;
        if (sel_dllp && dllp_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tlp_last        = DATA_BYTES'(last_byte_onehot(LPIF_MAX_BYTES'(tlp_bytevalid)));
    dllp_last       = DATA_BYTES'(last_byte_onehot(LPIF_MAX_BYTES'(dllp_bytevalid)));
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_bytevalid_d = out_bytevalid_q;
    out_tlpstart_d  = out_tlpstart_q;
    out_tlpend_d    = out_tlpend_q;
    out_dllpstart_d = out_dllpstart_q;
    out_dllpend_d   = out_dllpend_q;
`ifdef LPIF_TX_EDB_EN
    out_tlpedb_d    = out_tlpedb_q;
`endif
    // Bubbles clear every field so the PHY never sees stale markers.
    if (load) begin
      out_valid_d     = sel_tlp || sel_dllp;
      out_data_d      = sel_tlp ? tlp_data : (sel_dllp ? dllp_data : '0);
      out_bytevalid_d = sel_tlp ? tlp_bytevalid : (sel_dllp ? dllp_bytevalid : '0);
      out_tlpstart_d  = (sel_tlp && tlp_sop) ? FIRST_OH : '0;
      out_tlpend_d    = (sel_tlp && tlp_eop) ? tlp_last : '0;
      out_dllpstart_d = (sel_dllp && dllp_sop) ? FIRST_OH : '0;
      out_dllpend_d   = (sel_dllp && dllp_eop) ? dllp_last : '0;
`ifdef LPIF_TX_EDB_EN
      out_tlpedb_d    = '0;
      if (sel_tlp && tlp_eop && tlp_abort) begin
        out_tlpedb_d = tlp_last;
        out_tlpend_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_bytevalid_q <= '0;
      out_tlpstart_q  <= '0;
      out_tlpend_q    <= '0;
      out_dllpstart_q <= '0;
      out_dllpend_q   <= '0;
`ifdef LPIF_TX_EDB_EN
      out_tlpedb_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_bytevalid_q <= out_bytevalid_d;
      out_tlpstart_q  <= out_tlpstart_d;
      out_tlpend_q    <= out_tlpend_d;
      out_dllpstart_q <= out_dllpstart_d;
      out_dllpend_q   <= out_dllpend_d;
`ifdef LPIF_TX_EDB_EN
      out_tlpedb_q    <= out_tlpedb_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_bytevalid = out_bytevalid_q;
  assign out_tlpstart  = out_tlpstart_q;
  assign out_tlpend    = out_tlpend_q;
  assign out_dllpstart = out_dllpstart_q;
  assign out_dllpend   = out_dllpend_q;
`ifdef LPIF_TX_EDB_EN
  assign out_tlpedb    = out_tlpedb_q;
`endif
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lpif_tx_packet_arbiter.sv
// Directed bench for lpif_tx_packet_arbiter (8-byte beats, MAX_DLLP_RUN=4).
module tb_lpif_tx_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_enable;
  logic        tlp_valid, tlp_sop, tlp_eop;
  logic [63:0] tlp_data;
  logic [7:0]  tlp_bytevalid;
  logic        tlp_ready;
  logic        dllp_valid, dllp_sop, dllp_eop;
  logic [63:0] dllp_data;
  logic [7:0]  dllp_bytevalid;
  logic        dllp_ready;
  logic        out_ready, out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_bytevalid, out_tlpstart, out_tlpend, out_dllpstart, out_dllpend;
  logic        busy;
`ifdef LPIF_TX_EDB_EN
  logic        tlp_abort;
  logic [7:0]  out_tlpedb;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lpif_tx_packet_arbiter #(.DATA_BYTES(8), .MAX_DLLP_RUN(4)) dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable),
    .tlp_valid(tlp_valid), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
    .tlp_data(tlp_data), .tlp_bytevalid(tlp_bytevalid), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_sop(dllp_sop), .dllp_eop(dllp_eop),
    .dllp_data(dllp_data), .dllp_bytevalid(dllp_bytevalid), .dllp_ready(dllp_ready),
`ifdef LPIF_TX_EDB_EN
    .tlp_abort(tlp_abort), .out_tlpedb(out_tlpedb),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_bytevalid(out_bytevalid), .out_tlpstart(out_tlpstart), .out_tlpend(out_tlpend),
    .out_dllpstart(out_dllpstart), .out_dllpend(out_dllpend), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tlp(input logic v, input logic s, input logic e,
                         input logic [63:0] d, input logic [7:0] bv);
    tlp_valid = v; tlp_sop = s; tlp_eop = e; tlp_data = d; tlp_bytevalid = bv;
  endtask

  task automatic set_dllp(input logic v, input logic s, input logic e,
                          input logic [63:0] d, input logic [7:0] bv);
    dllp_valid = v; dllp_sop = s; dllp_eop = e; dllp_data = d; dllp_bytevalid = bv;
  endtask

  initial begin
    reset = 1'b0; tx_enable = 1'b1; out_ready = 1'b1;
    set_tlp(0, 0, 0, 64'h0, 8'h0);
    set_dllp(0, 0, 0, 64'h0, 8'h0);
`ifdef LPIF_TX_EDB_EN
    tlp_abort = 1'b0;
`endif
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tlpstart", out_tlpstart, 0);
    reset = 1'b1;
    tick();

    // valid without sop in IDLE is held, not accepted
    set_tlp(1, 0, 0, 64'hDEAD, 8'hFF); #1;
    chk("nosop_ready", tlp_ready, 0);
    tick();
    chk("nosop_out_valid", out_valid, 0);

    // 1: 3-beat TLP
    set_tlp(1, 1, 0, 64'h1111_1111_1111_1111, 8'hFF); #1;
    chk("t1_ready_b1", tlp_ready, 1);
    tick();
    chk("t1_b1_valid", out_valid, 1);
    chk("t1_b1_data", out_data, 64'h1111_1111_1111_1111);
    chk("t1_b1_tlpstart", out_tlpstart, 8'h01);
    chk("t1_b1_tlpend", out_tlpend, 8'h00);
    chk("t1_b1_busy", busy, 1);
    set_tlp(1, 0, 0, 64'h2222_2222_2222_2222, 8'hFF);
    tick();
    chk("t1_b2_data", out_data, 64'h2222_2222_2222_2222);
    chk("t1_b2_tlpstart", out_tlpstart, 8'h00);
    set_tlp(1, 0, 1, 64'h0000_0000_3333_3333, 8'h0F);
    tick();
    chk("t1_b3_bv", out_bytevalid, 8'h0F);
    chk("t1_b3_tlpend", out_tlpend, 8'h08);
    set_tlp(0, 0, 0, 64'h0, 8'h0);
    tick();
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 3: single-beat DLLP
    set_dllp(1, 1, 1, 64'h0000_AABB_CCDD_EEFF, 8'h3F); #1;
    chk("t3_dllp_ready", dllp_ready, 1);
    tick();
    chk("t3_dllpstart", out_dllpstart, 8'h01);
    chk("t3_dllpend", out_dllpend, 8'h20);
    chk("t3_tlpstart", out_tlpstart, 8'h00);
    chk("t3_busy", busy, 0);
    set_dllp(0, 0, 0, 64'h0, 8'h0);
    tick();
    chk("t3_after_valid", out_valid, 0);

    // 2: DLLP priority with TLP anti-starvation (4 DLLP, 1 TLP, DLLP)
    set_tlp(1, 1, 1, 64'h7, 8'h01);
    set_dllp(1, 1, 1, 64'hD, 8'h03);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t2_tlp_ready_%0d", i), tlp_ready, (i == 4) ? 1 : 0);
      chk($sformatf("t2_dllp_ready_%0d", i), dllp_ready, (i == 4) ? 0 : 1);
      tick();
      chk($sformatf("t2_tlpstart_%0d", i), out_tlpstart, (i == 4) ? 8'h01 : 8'h00);
      chk($sformatf("t2_dllpstart_%0d", i), out_dllpstart, (i == 4) ? 8'h00 : 8'h01);
    end
    set_tlp(0, 0, 0, 64'h0, 8'h0);
    set_dllp(0, 0, 0, 64'h0, 8'h0);
    tick();

    // 4: output stall mid-TLP
    set_tlp(1, 1, 0, 64'hA1, 8'hFF);
    tick();
    set_tlp(1, 0, 0, 64'hA2, 8'hFF);
    out_ready = 1'b0; #1;
    chk("t4_stall_ready", tlp_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_hold_data_%0d", i), out_data, 64'hA1);
      chk($sformatf("t4_hold_start_%0d", i), out_tlpstart, 8'h01);
    end
    chk("t4_hold_valid", out_valid, 1);
    out_ready = 1'b1; #1;
    chk("t4_resume_ready", tlp_ready, 1);
    tick();
    chk("t4_b2_data", out_data, 64'hA2);
    chk("t4_b2_start", out_tlpstart, 8'h00);
    set_tlp(1, 0, 1, 64'hA3, 8'h03);
    tick();
    chk("t4_b3_data", out_data, 64'hA3);
    chk("t4_b3_end", out_tlpend, 8'h02);
    set_tlp(0, 0, 0, 64'h0, 8'h0);
    tick();
    chk("t4_idle_valid", out_valid, 0);

    // 5: tx_enable drops during a 4-beat TLP
    set_tlp(1, 1, 0, 64'hB1, 8'hFF);
    tick();
    tx_enable = 1'b0;
    set_dllp(1, 1, 1, 64'hDD, 8'h01);
    set_tlp(1, 0, 0, 64'hB2, 8'hFF); #1;
    chk("t5_dllp_blocked_mid", dllp_ready, 0);
    tick();
    chk("t5_b2_data", out_data, 64'hB2);
    set_tlp(1, 0, 0, 64'hB3, 8'hFF);
    tick();
    chk("t5_b3_data", out_data, 64'hB3);
    set_tlp(1, 0, 1, 64'hB4, 8'hFF);
    tick();
    chk("t5_b4_data", out_data, 64'hB4);
    chk("t5_b4_end", out_tlpend, 8'h80);
    set_tlp(0, 0, 0, 64'h0, 8'h0); #1;
    chk("t5_dllp_ready_dis", dllp_ready, 0);
    tick();
    chk("t5_no_grant_valid", out_valid, 0);
    tick();
    chk("t5_no_grant_valid2", out_valid, 0);
    tx_enable = 1'b1; #1;
    chk("t5_dllp_ready_en", dllp_ready, 1);
    tick();
    chk("t5_dllp_start", out_dllpstart, 8'h01);
    set_dllp(0, 0, 0, 64'h0, 8'h0);
    tick();

    // 6: reset mid-packet, then clean restart
    set_tlp(1, 1, 0, 64'hC1, 8'hFF);
    tick();
    set_tlp(1, 0, 0, 64'hC2, 8'hFF);
    #1; reset = 1'b0; #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_tlpstart", out_tlpstart, 0);
    #1; reset = 1'b1;
    set_tlp(1, 1, 1, 64'hC9, 8'h01);
    tick();
    chk("t6_new_data", out_data, 64'hC9);
    chk("t6_new_start", out_tlpstart, 8'h01);
    chk("t6_new_end", out_tlpend, 8'h01);
`ifdef LPIF_TX_EDB_EN
    set_tlp(1, 1, 1, 64'hCA, 8'hFF);
    tlp_abort = 1'b1;
    tick();
    chk("t6_edb", out_tlpedb, 8'h80);
    chk("t6_edb_tlpend", out_tlpend, 8'h00);
    tlp_abort = 1'b0;
`endif
    set_tlp(0, 0, 0, 64'h0, 8'h0);
    tick();
    chk("t6_final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpif_tx_packet_arbiter.md
Name: lpif_tx_packet_arbiter

Overview:
Shares the single LPIF transmit byte path between two link-layer requesters: a TLP source and a DLLP source. Grants are packet-atomic, and the block produces per-byte start/end/valid framing masks toward the PHY TX framing logic. Arbitration is DLLP-priority with a TLP anti-starvation limit. New packets are gated by the link-up/enable input from the LTSSM.

Parameters:
DATA_BYTES, 8, bytes per beat; data width = 8*DATA_BYTES
MAX_DLLP_RUN, 4, consecutive DLLP grants allowed while a TLP waits (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
tx_enable  in  1  link in L0; new grants allowed only when 1
tlp_valid  in  1  TLP beat valid
tlp_sop  in  1  first beat of TLP
tlp_eop  in  1  last beat of TLP
tlp_data  in  8*DATA_BYTES  TLP bytes, byte 0 = LSB
tlp_bytevalid  in  DATA_BYTES  valid byte mask, contiguous from byte 0
tlp_ready  out  1  TLP beat accepted
dllp_valid, dllp_sop, dllp_eop, dllp_data, dllp_bytevalid, dllp_ready  same meanings for the DLLP source
out_ready  in  1  downstream accepts beat
out_valid  out  1  beat valid
out_data  out  8*DATA_BYTES  bytes
out_bytevalid  out  DATA_BYTES  per-byte valid
out_tlpstart / out_tlpend / out_dllpstart / out_dllpend  out  DATA_BYTES each  one-hot per-byte framing markers
busy  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; state IDLE; dllp_run counter 0.
- States:
  - IDLE: stays in IDLE when no grant.
  - TLP: entered from IDLE when a TLP is granted; returns to IDLE on the accepted TLP eop beat.
  - DLLP: entered from IDLE when a DLLP is granted; returns to IDLE on the accepted DLLP eop beat.
- Grant is evaluated in IDLE only. Requires tx_enable=1 and a requester with valid&sop.
  - Only one requester: that requester wins.
  - Both requesting: DLLP wins unless dllp_run >= MAX_DLLP_RUN, in which case TLP wins.
- The grant beat is accepted in the same cycle. No bubble between back-to-back packets: on an eop accept, IDLE arbitration happens the next cycle.
- dllp_run:
  - Increments (saturating at 15) on each DLLP grant made while tlp_valid=1.
  - Clears on any TLP grant, or when tlp_valid=0 in IDLE.
- Handshake: out register loads when (!out_valid || out_ready) holds. The granted source's ready equals that condition and the other ready is 0. Latency from accept to out_valid is 1 cycle. Stalled output holds all fields stable.
- Framing:
  - out_tlpstart[0]=1 on the TLP sop beat.
  - out_tlpend has a bit at the index of the highest set bytevalid on the TLP eop beat.
  - DLLP markers are generated the same way.
  - sop&eop on the same beat sets both markers.
- valid without sop in IDLE is a protocol error. The beat is not accepted and is held until a sop arrives; it is never dropped silently.
- tx_enable falling mid-packet: the current packet completes; no new grant until tx_enable=1.
- Reset mid-packet returns to IDLE immediately and drops the partial packet.

Optional Feature:
LPIF_TX_EDB_EN:
- Defined: adds input tlp_abort (1, qualified with TLP eop) and output out_tlpedb (DATA_BYTES). On an aborted TLP eop, the marker goes to out_tlpedb instead of out_tlpend, and the abort is counted as a TLP grant completion.
- Undefined: neither port exists and TLP end is always reported on out_tlpend.

Decomposition:
- Shared package lpif_pkg holds:
  - the state enum {ST_IDLE, ST_TLP, ST_DLLP}
  - the DATA_BYTES default
  - a function last_byte_onehot(bytevalid) returning the highest-set-bit one-hot, also reused by RX framing.
- Sub-module lpif_tx_grant: the combinational grant decision plus the dllp_run counter.

Test Plan:
1. Single 3-beat TLP, DLLP idle, out_ready=1 -> out beats on cycles 1–3; beat1 out_tlpstart=0x01; beat3 with bytevalid=0x0F has out_tlpend=0x08.
2. TLP and DLLP sop asserted together, MAX_DLLP_RUN=4, DLLPs continuously pending -> four DLLPs granted, then one TLP, then DLLPs again.
3. 1-beat DLLP with bytevalid=0x3F -> out_dllpstart=0x01 and out_dllpend=0x20 on the same beat.
4. out_ready held 0 for 5 cycles mid-TLP -> tlp_ready=0; out_data/markers stable; no beat lost or duplicated.
5. tx_enable drops on beat 2 of a 4-beat TLP -> all 4 beats are emitted; a pending DLLP is not granted until tx_enable=1.
6. Reset asserted mid-packet -> all outputs are 0 the same cycle; after release, a new sop packet is granted cleanly. With LPIF_TX_EDB_EN, an aborted TLP gives out_tlpedb=0x80 and out_tlpend=0.
